// File: rtl/cntr_pkg.sv
// -----------------------------------------------------------------------------
// cntr_pkg
// Shared definitions for the counter family and the blocks that instantiate it.
//   clog2   : ceiling log2, usable in localparam/parameter expressions
//   CNT_UP  : up_dn value selecting count-up
//   CNT_DN  : up_dn value selecting count-down
// -----------------------------------------------------------------------------
package cntr_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Number of bits needed to hold 0..value-1; returns 0 for value <= 1.
  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned     bits;
    longint unsigned rem;
    bits = 0;
    if (value > 64'd1) begin
      rem = value - 64'd1;
      while (rem != 64'd0) begin
        bits = bits + 1;
        rem  = rem >> 1;
      end
    end
    return bits;
  endfunction

endpackage : cntr_pkg

// File: rtl/updn_mod_cntr.sv
// -----------------------------------------------------------------------------
// updn_mod_cntr
// Synchronous up/down modulo-MODULUS counter with synchronous clear, parallel
// load (clamped to MODULUS-1), combinational cascade carry and a registered
// one-cycle wrap pulse.
//
// Parameters
//   WIDTH    : counter width, 1..32
//   MODULUS  : count range 0..MODULUS-1, 2..2**WIDTH
//
// Ports
//   clk      : rising-edge clock
//   rstn     : asynchronous active-low reset (count=0, wrap=0)
//   cnt_en   : count enable / carry-in from the previous stage
//   up_dn    : 1 = up (CNT_UP), 0 = down (CNT_DN)
//   clr      : synchronous clear, highest priority
//   load     : synchronous load of load_val
//   load_val : load value; values >= MODULUS load MODULUS-1
//   count    : registered count
//   carry    : combinational terminal-count carry-out (next stage's cnt_en)
//   wrap     : registered pulse, high the cycle after a terminal event
//
// Build option
//   UPDN_MOD_CNTR_SATURATE_EN : when defined, an enabled count at the terminal
//   value holds there instead of wrapping; carry/wrap keep asserting.
// -----------------------------------------------------------------------------
module updn_mod_cntr
  import cntr_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cnt_en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             wrap
);

  // MODULUS-1 always fits in WIDTH bits, including MODULUS == 2**WIDTH.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] term_val;
  logic             at_term;
  logic [WIDTH-1:0] load_clamped;

  // Compare in 64 bits so MODULUS == 2**WIDTH never truncates to 0.
  assign load_clamped = (64'(load_val) >= MODULUS) ? MAX_VAL : load_val;

  assign term_val = (up_dn == CNT_UP) ? MAX_VAL : '0;
  assign at_term  = (count == term_val);

  // Zero-latency carry: cascaded stages count on the same edge as this one.
  assign carry = cnt_en & at_term & ~clr & ~load;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; only count and wrap exist, and both are reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      // carry is already zero under clr, load or hold, so this also clears wrap.
      wrap <= carry;
      if (clr) begin
        count <= '0;
      end else if (load) begin
        count <= load_clamped;
      end else if (cnt_en) begin
        if (at_term) begin
`ifdef UPDN_MOD_CNTR_SATURATE_EN
          count <= count;
`else
          count <= (up_dn == CNT_UP) ? '0 : MAX_VAL;
`endif
        end else if (up_dn == CNT_UP) begin
          count <= count + WIDTH'(1);
        end else begin
          count <= count - WIDTH'(1);
        end
      end
    end
  end

endmodule : updn_mod_cntr
